main_memory_port: RTL and testbench
===================================

# main_memory_port

Main-memory responder on the downstream side of the cache control FSM. It accepts single-cycle `MStrobe` requests (read when `MRW`=0, write when `MRW`=1) and models a fixed-latency word-addressed backing store. It returns `MReady` plus read data after `LATENCY` cycles. `LATENCY` defaults to 4 so that `MReady` coincides with the controller's wait-state counter expiry.

## Interface
Parameters:
- `AW`, 8: address width; the array holds 2**`AW` words.
- `DW`, 32: data word width.
- `LATENCY`, 4: clock edges from the request-sampling edge to the `MReady` cycle; legal range 1..255.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all control state immediately.
- `MStrobe`  in  1  request valid for one cycle.
- `MRW`  in  1  0 = read, 1 = write; sampled with `MStrobe`.
- `MAddr`  in  `AW`  word address; sampled with `MStrobe`.
- `MDataIn`  in  `DW`  write data; sampled with `MStrobe`.
- `FlipPar`  in  1  test hook that inverts the stored parity bit of a write; sampled with `MStrobe`.
- `MDataOut`  out  `DW`  read data; valid while `MReady`=1 on a read, held until the next read completes.
- `MReady`  out  1  one-cycle completion pulse for both reads and writes.
- `MBusy`  out  1  high while a request is pending (`BUSY` state).
- `OvrErr`  out  1  one-cycle pulse when an `MStrobe` is dropped because the block is busy.
- `MErr`  out  1  parity error on a read completion; coincident with `MReady`.

## Operation
- States: `IDLE`, `BUSY`, `DONE`. Reset state is `IDLE`.
- Reset values: `MDataOut`=0, `MReady`=0, `MBusy`=0, `OvrErr`=0, `MErr`=0; counter=0. Array contents are not cleared.
- `IDLE` + `MStrobe`: capture `MRW`, `MAddr`, `MDataIn`, `FlipPar`; load counter with `LATENCY`-1; go to `BUSY`.
- `BUSY`: when counter≠0, decrement it. When counter=0, perform the access at the next edge and go to `DONE`.
  - Write: array[addr] ← data.
  - Read: `MDataOut` ← array[addr].
- `BUSY` + `MStrobe`: request dropped, no state change, `OvrErr`=1 for the following cycle.
- `DONE`: `MReady`=1 for exactly this cycle.
  - `DONE` + `MStrobe`: accepted as in `IDLE` (back-to-back requests allowed); go to `BUSY`.
  - Otherwise go to `IDLE`.
- `MBusy` = (state==`BUSY`).
- Write data is committed only on the `BUSY`→`DONE` edge.
- Reset asserted mid-request: the pending write is discarded (array unchanged), the pending read is discarded, and no `MReady` is issued.

## Timing
- Request sampled at edge k. `MReady` is high in the cycle following edge k+`LATENCY`.
- With `LATENCY`=1: edge k goes to `BUSY` with counter 0; edge k+1 goes to `DONE`.
- Minimum request spacing is `LATENCY`+1 cycles (strobe in the `DONE` cycle).
- Read data becomes visible at the same edge that raises `MReady`. There is no combinational path from any input to any output.
- Counter width is ceil(log2(`LATENCY`))+1 bits; the counter never wraps.
- Write followed by a read to the same address, back-to-back: the read returns the new data.

## Configuration
- Macro: `MAIN_MEM_PARITY_EN`.
- Defined:
  - Each word stores one extra even-parity bit, computed on write and XORed with the captured `FlipPar`.
  - On read completion the parity is recomputed. `MErr`=1 in the `MReady` cycle if it mismatches the stored bit; otherwise `MErr`=0.
  - Write completions always drive `MErr`=0.
- Undefined: no parity storage, `MErr` tied 0, `FlipPar` ignored.

## Test plan
- Write addr 0x10 data 0xDEADBEEF, then read 0x10 → `MReady` exactly 4 edges after each strobe edge; read `MDataOut`=0xDEADBEEF; `MBusy` high for 4 cycles per request.
- `LATENCY`=1: write 0x01←0x5, then read 0x01 in the `DONE` cycle → second `MReady` 2 cycles after the first; data 0x5.
- Strobe read 0x20, then strobe again 2 cycles later → `OvrErr` pulses once; only one `MReady`; `MDataOut` = array[0x20].
- Write 0x30←0xAAAA, then strobe write 0x30←0x5555 and assert `reset` during `BUSY` → `MReady` never rises and all outputs return to 0 immediately. A subsequent read of 0x30 returns 0xAAAA.
- Reset deasserted with `MStrobe`=0 for 10 cycles → state stays `IDLE`, all outputs 0.
- `MAIN_MEM_PARITY_EN` defined: write 0x40←0x1 with `FlipPar`=1, then read 0x40 → `MErr`=1 with `MReady`, data 0x1. Write 0x41 with `FlipPar`=0, then read 0x41 → `MErr`=0.

Source files
------------

// File: rtl/main_memory_port.sv
// Fixed-latency word-addressed main-memory responder behind the cache controller.
// Optional feature: define MAIN_MEM_PARITY_EN for per-word even parity with error reporting.
module main_memory_port #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int LATENCY = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          MStrobe,
   input  logic          MRW,
   input  logic [AW-1:0] MAddr,
   input  logic [DW-1:0] MDataIn,
   input  logic          FlipPar,
   output logic [DW-1:0] MDataOut,
   output logic          MReady,
   output logic          MBusy,
   output logic          OvrErr,
   output logic          MErr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int            CW       = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   function automatic logic even_parity(input logic [DW-1:0] word);
      even_parity = ^word;
   endfunction

   logic [1:0]    state_r;
   logic [1:0]    state_s;
   logic [CW-1:0] cnt_r;
   logic          rw_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] data_r;
   logic          accept_s;
   logic          drop_s;
   logic          access_s;

   logic [DW-1:0] mem_r [0:(1<<AW)-1];

   // Next-state decode; access_s marks the BUSY->DONE edge where the array is touched.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      drop_s   = 1'b0;
      access_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (MStrobe) begin
               accept_s = 1'b1;
               state_s  = BUSY;
            end else begin
               state_s  = IDLE;
            end
         end
         BUSY: begin
            drop_s = MStrobe;
            if (cnt_r == CNT_ZERO) begin
               access_s = 1'b1;
               state_s  = DONE;
            end else begin
               state_s  = BUSY;
            end
         end
         DONE: begin
            if (MStrobe) begin
               accept_s = 1'b1;
               state_s  = BUSY;
            end else begin
               state_s  = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control state, request capture and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         cnt_r    <= CNT_ZERO;
         rw_r     <= 1'b0;
         addr_r   <= {AW{1'b0}};
         data_r   <= {DW{1'b0}};
         MDataOut <= {DW{1'b0}};
         MReady   <= 1'b0;
         MBusy    <= 1'b0;
         OvrErr   <= 1'b0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            cnt_r  <= CNT_LOAD;
            rw_r   <= MRW;
            addr_r <= MAddr;
            data_r <= MDataIn;
         end else if (state_r == BUSY && cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
         if (access_s && !rw_r) begin
            MDataOut <= mem_r[addr_r];
         end else begin
            MDataOut <= MDataOut;
         end
         MReady <= access_s;
         MBusy  <= (state_s == BUSY);
         OvrErr <= drop_s;
      end
   end

   // Backing store: never reset; writes commit only on the completion edge.
   always_ff @(posedge clk) begin
      if (access_s && rw_r) begin
         mem_r[addr_r] <= data_r;
      end
   end

`ifdef MAIN_MEM_PARITY_EN
   logic flip_r;
   logic par_mem_r [0:(1<<AW)-1];

   // Capture the parity-inversion hook alongside the rest of the request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flip_r <= 1'b0;
      end else if (accept_s) begin
         flip_r <= FlipPar;
      end else begin
         flip_r <= flip_r;
      end
   end

   // Parity side-array, written in step with the data array.
   always_ff @(posedge clk) begin
      if (access_s && rw_r) begin
         par_mem_r[addr_r] <= even_parity(data_r) ^ flip_r;
      end
   end

   // Parity check on read completion; writes and idle cycles report no error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MErr <= 1'b0;
      end else if (access_s && !rw_r) begin
         MErr <= (even_parity(mem_r[addr_r]) != par_mem_r[addr_r]);
      end else begin
         MErr <= 1'b0;
      end
   end
`else
   logic unused_s;
   assign unused_s = FlipPar ^ even_parity(data_r);
   assign MErr     = 1'b0;
`endif

endmodule

// File: tb/tb_main_memory_port.sv
// Directed self-checking bench for main_memory_port (LATENCY=4 and LATENCY=1 instances).
module tb_main_memory_port;

   logic        clk = 1'b0;
   logic        reset;
   logic        strobe4, strobe1, rw_in, flip_in;
   logic [7:0]  addr_in;
   logic [31:0] din;
   logic [31:0] dout4, dout1;
   logic        rdy4, busy4, ovr4, err4;
   logic        rdy1, busy1, ovr1, err1;

   int vec_cnt = 0;
   int err_cnt = 0;

`ifdef MAIN_MEM_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   main_memory_port #(.AW(8), .DW(32), .LATENCY(4)) dut4 (
      .clk(clk), .reset(reset), .MStrobe(strobe4), .MRW(rw_in), .MAddr(addr_in),
      .MDataIn(din), .FlipPar(flip_in), .MDataOut(dout4), .MReady(rdy4),
      .MBusy(busy4), .OvrErr(ovr4), .MErr(err4)
   );

   main_memory_port #(.AW(8), .DW(32), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .MStrobe(strobe1), .MRW(rw_in), .MAddr(addr_in),
      .MDataIn(din), .FlipPar(flip_in), .MDataOut(dout1), .MReady(rdy1),
      .MBusy(busy1), .OvrErr(ovr1), .MErr(err1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one request (called #1 after an edge) and return in the MReady cycle.
   task automatic req(input bit sel, input logic rw, input logic [7:0] a, input logic [31:0] d,
                      input logic fp, output int lat, output int busy_n);
      rw_in = rw; addr_in = a; din = d; flip_in = fp;
      if (sel) strobe1 = 1'b1; else strobe4 = 1'b1;
      step();
      strobe1 = 1'b0; strobe4 = 1'b0;
      lat = 0; busy_n = 0;
      while (((sel ? rdy1 : rdy4) == 1'b0) && lat < 20) begin
         if (sel ? busy1 : busy4) busy_n++;
         step();
         lat++;
      end
   endtask

   initial begin
      int lat, bn, ovr_n, rdy_n;
      logic [31:0] cap;
      logic [36:0] acc;
      reset = 1'b1; strobe4 = 1'b0; strobe1 = 1'b0; rw_in = 1'b0;
      flip_in = 1'b0; addr_in = 8'h00; din = 32'h0;
      step(); step();
      chk("rst_state", {dout4, rdy4, busy4, ovr4, err4}, 64'h0);
      reset = 1'b0;

      acc = 37'h0;
      for (int i = 0; i < 10; i++) begin
         step();
         acc = acc | {dout4, rdy4, busy4, ovr4, err4, rdy1};
      end
      chk("idle_quiet", acc, 64'h0);

      // Basic write then read with latency and busy-width checks.
      req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, lat, bn);
      chk("wr_latency", lat, 4);
      chk("wr_busy", bn, 4);
      chk("wr_merr", err4, 1'b0);
      step();
      chk("wr_pulse", rdy4, 1'b0);
      req(1'b0, 1'b0, 8'h10, 32'h0, 1'b0, lat, bn);
      chk("rd_latency", lat, 4);
      chk("rd_busy", bn, 4);
      chk("rd_data", dout4, 32'hDEADBEEF);
      step();
      chk("rd_pulse", rdy4, 1'b0);
      chk("rd_hold", dout4, 32'hDEADBEEF);

      // LATENCY=1 with the read strobed in the DONE cycle.
      req(1'b1, 1'b1, 8'h01, 32'h5, 1'b0, lat, bn);
      chk("l1_wr_latency", lat, 1);
      req(1'b1, 1'b0, 8'h01, 32'h0, 1'b0, lat, bn);
      chk("l1_rd_latency", lat, 1);
      chk("l1_rd_busy", bn, 1);
      chk("l1_rd_data", dout1, 32'h5);
      step();

      // Overrun: second strobe two cycles into a read is dropped.
      req(1'b0, 1'b1, 8'h20, 32'h12345678, 1'b0, lat, bn);
      step();
      req(1'b0, 1'b1, 8'h21, 32'hCAFEF00D, 1'b0, lat, bn);
      step();
      rw_in = 1'b0; addr_in = 8'h20; strobe4 = 1'b1;
      step();
      strobe4 = 1'b0;
      step();
      rw_in = 1'b1; addr_in = 8'h21; din = 32'hBAD0BAD0; strobe4 = 1'b1;
      ovr_n = 0; rdy_n = 0; cap = 32'h0;
      for (int i = 0; i < 12; i++) begin
         step();
         strobe4 = 1'b0;
         ovr_n += int'(ovr4);
         rdy_n += int'(rdy4);
         if (rdy4) cap = dout4;
      end
      chk("ovr_pulses", ovr_n, 1);
      chk("ovr_readies", rdy_n, 1);
      chk("ovr_data", cap, 32'h12345678);
      req(1'b0, 1'b0, 8'h21, 32'h0, 1'b0, lat, bn);
      chk("ovr_no_write", dout4, 32'hCAFEF00D);
      step();

      // Reset during a pending write discards it.
      req(1'b0, 1'b1, 8'h30, 32'h0000AAAA, 1'b0, lat, bn);
      step();
      rw_in = 1'b1; addr_in = 8'h30; din = 32'h00005555; strobe4 = 1'b1;
      step();
      strobe4 = 1'b0;
      step();
      chk("pre_rst_busy", busy4, 1'b1);
      reset = 1'b1;
      #1;
      chk("rst_async", {dout4, rdy4, busy4, ovr4, err4}, 64'h0);
      step(); step();
      reset = 1'b0;
      rdy_n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         rdy_n += int'(rdy4);
      end
      chk("rst_no_ready", rdy_n, 0);
      req(1'b0, 1'b0, 8'h30, 32'h0, 1'b0, lat, bn);
      chk("rst_old_data", dout4, 32'h0000AAAA);
      step();

      // Back-to-back write then read of the same address.
      req(1'b0, 1'b1, 8'h50, 32'h0F0F0F0F, 1'b0, lat, bn);
      chk("b2b_wr_hold", dout4, 32'h0000AAAA);
      req(1'b0, 1'b0, 8'h50, 32'h0, 1'b0, lat, bn);
      chk("b2b_latency", lat, 4);
      chk("b2b_data", dout4, 32'h0F0F0F0F);
      step();

      // Parity: flipped write reports an error on read only when parity is built in.
      req(1'b0, 1'b1, 8'h40, 32'h1, 1'b1, lat, bn);
      chk("par_wr_merr", err4, 1'b0);
      step();
      req(1'b0, 1'b0, 8'h40, 32'h0, 1'b0, lat, bn);
      chk("par_flip_merr", err4, PAR_EN);
      chk("par_flip_data", dout4, 32'h1);
      step();
      chk("par_merr_pulse", err4, 1'b0);
      req(1'b0, 1'b1, 8'h41, 32'h7, 1'b0, lat, bn);
      step();
      req(1'b0, 1'b0, 8'h41, 32'h0, 1'b0, lat, bn);
      chk("par_clean_merr", err4, 1'b0);
      chk("par_clean_data", dout4, 32'h7);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
